game_sequencer: RTL and testbench

//  Top-level game-flow controller for the pinball main screen. Sequences the start,

---
 rtl/game_sequencer.sv | 131 +++++++++++++
 tb/tb_game_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game-flow controller for the pinball main screen: start, serve, play,
// ball-lost, level-up, game-over and win phases with life/score/level.
module game_sequencer #(
    parameter logic [3:0] INIT_LIVES      = 4'd3,
    parameter logic [3:0] SCORE_PER_LEVEL = 4'd5,
    parameter logic [3:0] MAX_LEVEL       = 4'd3,
    parameter logic [5:0] DELAY_FRAMES    = 6'd60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       key5IsPressed,
    input  logic       collisionSmileyBorderBottom,
    input  logic       collisionSmileyObstacleGood,
    input  logic       collisionSmileyObstacleBad,
    output logic       pause,
    output logic       reset_level,
    output logic [3:0] life,
    output logic [3:0] score,
    output logic [3:0] level,
    output logic [1:0] screen_sel
);

    typedef enum logic [2:0] {
        IDLE, SERVE, PLAY, LOST, LVLUP, OVER, WIN
    } state_t;

    state_t     state, stateN;
    logic       key5D;
    logic [5:0] cnt, cntN;
    logic [3:0] lifeN, scoreN, levelN;
    logic       pauseN, resetLevelN;
    logic [1:0] screenN;
    logic       keyRise;

    assign keyRise = key5IsPressed & ~key5D;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            key5D       <= 1'b0;
            cnt         <= '0;
            pause       <= 1'b1;
            reset_level <= 1'b0;
            life        <= INIT_LIVES;
            score       <= '0;
            level       <= 4'd1;
            screen_sel  <= 2'd0;
        end else begin
            state       <= stateN;
            key5D       <= key5IsPressed;
            cnt         <= cntN;
            pause       <= pauseN;
            reset_level <= resetLevelN;
            life        <= lifeN;
            score       <= scoreN;
            level       <= levelN;
            screen_sel  <= screenN;
        end
    end

    always_comb begin
        stateN      = state;
        cntN        = cnt;
        lifeN       = life;
        scoreN      = score;
        levelN      = level;
        resetLevelN = 1'b0;
        unique case (state)
            IDLE: begin
                if (keyRise) begin
                    lifeN       = INIT_LIVES;
                    scoreN      = '0;
                    levelN      = 4'd1;
                    resetLevelN = 1'b1;
                    stateN      = SERVE;
                end
            end
            SERVE: begin
                if (keyRise) stateN = PLAY;
            end
            PLAY: begin
                // One event per frame; bottom beats bad beats good.
                if (startOfFrame) begin
                    if (collisionSmileyBorderBottom) begin
                        lifeN  = life - 4'd1;
                        stateN = (life == 4'd1) ? OVER : LOST;
                    end else if (collisionSmileyObstacleBad) begin
                        if (score != 4'd0) scoreN = score - 4'd1;
                    end else if (collisionSmileyObstacleGood) begin
                        if (score == SCORE_PER_LEVEL - 4'd1) begin
                            scoreN = '0;
                            stateN = LVLUP;
                        end else begin
                            scoreN = score + 4'd1;
                        end
                    end
                end
            end
            LOST, LVLUP: begin
                if (startOfFrame) begin
                    if (cnt == DELAY_FRAMES - 6'd1) begin
                        cntN = '0;
                        if (state == LVLUP && level == MAX_LEVEL) begin
                            stateN = WIN;
                        end else begin
                            if (state == LVLUP) levelN = level + 4'd1;
                            resetLevelN = 1'b1;
                            stateN      = SERVE;
                        end
                    end else begin
                        cntN = cnt + 6'd1;
                    end
                end
            end
            OVER, WIN: begin
                if (keyRise) stateN = IDLE;
            end
            default: stateN = IDLE;
        endcase
        if (stateN != state) cntN = '0;
        pauseN = (stateN != PLAY);
        unique case (stateN)
            IDLE:    screenN = 2'd0;
            OVER:    screenN = 2'd2;
            WIN:     screenN = 2'd3;
            default: screenN = 2'd1;
        endcase
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a phase-level game model predicts
// every clk's outputs; a negedge monitor compares them to the DUT.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       resetN;
    logic       sof, key, bottom, good, bad;
    logic       pause, reset_level;
    logic [3:0] life, score, level;
    logic [1:0] screen_sel;

    game_sequencer dut (
        .clk                         (clk),
        .resetN                      (resetN),
        .startOfFrame                (sof),
        .key5IsPressed               (key),
        .collisionSmileyBorderBottom (bottom),
        .collisionSmileyObstacleGood (good),
        .collisionSmileyObstacleBad  (bad),
        .pause                       (pause),
        .reset_level                 (reset_level),
        .life                        (life),
        .score                       (score),
        .level                       (level),
        .screen_sel                  (screen_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pause;
        logic       rl;
        logic [3:0] life;
        logic [3:0] score;
        logic [3:0] level;
        logic [1:0] scr;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   failed   = 0;

    // Reference model: game phase, counters and key history.
    string mPhase;
    int    mLife, mScore, mLevel, mCnt;
    bit    mKeyD, mRl;

    task automatic modelReset();
        mPhase = "IDLE";
        mLife  = 3;
        mScore = 0;
        mLevel = 1;
        mCnt   = 0;
        mKeyD  = 0;
        mRl    = 0;
    endtask

    task automatic modelStep();
        exp_t e;
        bit   rise;
        if (!resetN) begin
            modelReset();
        end else begin
            rise  = key && !mKeyD;
            mKeyD = key;
            mRl   = 0;
            if (mPhase == "IDLE") begin
                if (rise) begin
                    mLife = 3; mScore = 0; mLevel = 1;
                    mRl = 1; mPhase = "SERVE";
                end
            end else if (mPhase == "SERVE") begin
                if (rise) mPhase = "PLAY";
            end else if (mPhase == "PLAY") begin
                if (sof && bottom) begin
                    mLife  = mLife - 1;
                    mPhase = (mLife == 0) ? "OVER" : "LOST";
                end else if (sof && bad) begin
                    mScore = (mScore > 0) ? mScore - 1 : 0;
                end else if (sof && good) begin
                    mScore = mScore + 1;
                    if (mScore == 5) begin
                        mScore = 0;
                        mPhase = "LVLUP";
                    end
                end
            end else if (mPhase == "LOST" || mPhase == "LVLUP") begin
                if (sof) mCnt++;
                if (mCnt == 60) begin
                    mCnt = 0;
                    if (mPhase == "LVLUP" && mLevel == 3) begin
                        mPhase = "WIN";
                    end else begin
                        if (mPhase == "LVLUP") mLevel++;
                        mRl = 1;
                        mPhase = "SERVE";
                    end
                end
            end else begin
                if (rise) mPhase = "IDLE";
            end
        end
        e.pause = (mPhase != "PLAY");
        e.rl    = mRl;
        e.life  = 4'(mLife);
        e.score = 4'(mScore);
        e.level = 4'(mLevel);
        e.scr   = (mPhase == "IDLE") ? 2'd0 :
                  (mPhase == "OVER") ? 2'd2 :
                  (mPhase == "WIN")  ? 2'd3 : 2'd1;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = '{pause, reset_level, life, score, level, screen_sel};
            compared++;
            if (a !== e) begin
                failed++;
                $display("FAIL sb t=%0t got p=%b rl=%b life=%0d score=%0d lvl=%0d scr=%0d need p=%b rl=%b life=%0d score=%0d lvl=%0d scr=%0d",
                         $time, a.pause, a.rl, a.life, a.score, a.level, a.scr,
                         e.pause, e.rl, e.life, e.score, e.level, e.scr);
            end
        end
    end

    task automatic check(string name, int act, int req);
        compared++;
        if (act != req) begin
            failed++;
            $display("FAIL %s got %0d need %0d", name, act, req);
        end
    endtask

    task automatic step();
        modelStep();
        @(negedge clk);
        #1;
    endtask

    task automatic noise();
        bottom = 1'($urandom);
        good   = 1'($urandom);
        bad    = 1'($urandom);
    endtask

    task automatic frame(bit bo, bit ba, bit go);
        bottom = bo; bad = ba; good = go; sof = 1'b1;
        step();
        sof = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            noise();
            step();
        end
    endtask

    task automatic frames(int n);
        repeat (n) frame(0, 0, 0);
    endtask

    task automatic pressKey();
        key = 1'b1;
        step();
        key = 1'b0;
        step();
    endtask

    initial begin
        resetN = 1'b0;
        sof = 0; key = 0; bottom = 0; good = 0; bad = 0;
        modelReset();
        repeat (3) step();
        resetN = 1'b1;
        step();
        // serve then play
        pressKey();
        pressKey();
        // level 1 cleared, delay, serve at level 2
        repeat (5) frame(0, 0, 1);
        frames(60);
        pressKey();
        // bottom and good together: only life drops
        frame(1, 0, 1);
        frames(60);
        pressKey();
        // bad saturation, then bad from 2
        repeat (3) frame(0, 1, 0);
        repeat (2) frame(0, 0, 1);
        frame(0, 1, 0);
        // remaining lives lost, game over, back to start
        frame(1, 0, 0);
        frames(60);
        pressKey();
        frame(1, 0, 0);
        repeat (3) step();
        pressKey();
        // new game, clear all three levels
        pressKey();
        pressKey();
        for (int lv = 1; lv <= 3; lv++) begin
            repeat (5) frame(0, 0, 1);
            if (lv < 3) begin
                frames(60);
                pressKey();
            end
        end
        // key held across LVLUP->WIN must not restart
        key = 1'b1;
        frames(60);
        repeat (8) step();
        key = 1'b0;
        step();
        pressKey();
        // async reset in the middle of a LOST delay
        pressKey();
        pressKey();
        frame(1, 0, 0);
        frames(20);
        #1;
        resetN = 1'b0;
        sb.delete();
        modelReset();
        #1;
        check("rst_pause", int'(pause), 1);
        check("rst_rl", int'(reset_level), 0);
        check("rst_life", int'(life), 3);
        check("rst_score", int'(score), 0);
        check("rst_level", int'(level), 1);
        check("rst_scr", int'(screen_sel), 0);
        repeat (2) step();
        resetN = 1'b1;
        step();
        // randomized play
        for (int i = 0; i < 4000; i++) begin
            key    = ($urandom_range(0, 9) == 0);
            sof    = ($urandom_range(0, 2) == 0);
            bottom = ($urandom_range(0, 7) == 0);
            bad    = ($urandom_range(0, 3) == 0);
            good   = ($urandom_range(0, 1) == 0);
            step();
        end
        sof = 0; key = 0;
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, failed);
        $finish;
    end

endmodule
